// File: rtl/cmem_if.sv
// Bus bundle for the cmem single-port synchronous memory.
// The master drives the access controls and the slave returns registered read data.
interface cmem_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AW    = 6
);
   logic             cen;
   logic             wen;
   logic [AW-1:0]    a;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;

   modport master (output cen, output wen, output a, output d, input q);
   modport slave  (input cen, input wen, input a, input d, output q);
endinterface

// File: rtl/cmem.sv
// Single-port synchronous DEPTH x WIDTH memory with registered read data.
// A synchronous reset clears both the read register and every storage word.
module cmem #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = 6
) (
   input  logic   clk,
   input  logic   rstn,
   cmem_if.slave  bus
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Reset wins over any access in the same cycle, so X on cen/wen cannot disturb storage.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         bus.q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[AW'(i)] <= '0;
         end
      end else if (!bus.cen) begin
         if (!bus.wen) begin
            mem[bus.a] <= bus.d;
         end else begin
            bus.q <= mem[bus.a];
         end
      end
   end

endmodule

// File: tb/tb_cmem.sv
// Self-checking bench for cmem: a reference model pushes the expected Q for every
// driven cycle into a scoreboard that a negedge monitor pops and compares.
module tb_cmem;
   localparam int unsigned WIDTH = 16;
   localparam int unsigned DEPTH = 64;
   localparam int unsigned AW    = 6;

   logic clk;
   logic rstn;
   int   checks;
   int   errors;

   logic [WIDTH-1:0] mdl [DEPTH];
   logic [WIDTH-1:0] mq;
   logic [WIDTH-1:0] sb_val [$];
   string            sb_tag [$];

   cmem_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

   cmem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                        input logic [WIDTH-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, advance the model, queue the expected Q after the edge.
   task automatic drive(input logic r, input logic c, input logic w,
                        input logic [AW-1:0] addr, input logic [WIDTH-1:0] data,
                        input string tag);
      rstn    = r;
      bus.cen = c;
      bus.wen = w;
      bus.a   = addr;
      bus.d   = data;
      if (r == 1'b0) begin
         for (int i = 0; i < int'(DEPTH); i++) mdl[i] = '0;
         mq = '0;
      end else if (c == 1'b0) begin
         if (w == 1'b0) mdl[addr] = data;
         else           mq = mdl[addr];
      end
      sb_val.push_back(mq);
      sb_tag.push_back(tag);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if ($time > 1 && sb_val.size() > 0) begin
         check(sb_tag.pop_front(), bus.q, sb_val.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [WIDTH-1:0] di;
      checks  = 0;
      errors  = 0;
      mq      = '0;
      rstn    = 1'b0;
      bus.cen = 1'b1;
      bus.wen = 1'b1;
      bus.a   = '0;
      bus.d   = '0;

      // Reset with unknown controls; then a plain reset cycle.
      drive(1'b0, 1'bx, 1'bx, 6'd9, 16'h1111, "rst_x");
      drive(1'b0, 1'b1, 1'b1, 6'd0, 16'h0000, "rst");
      check("rst_q", bus.q, 16'h0000);
      drive(1'b1, 1'b0, 1'b1, 6'd9, 16'h0000, "rst_x_mem");

      // Basic write then read.
      drive(1'b1, 1'b0, 1'b0, 6'd1, 16'd350, "wr350");
      drive(1'b1, 1'b0, 1'b1, 6'd1, 16'd0, "rd350");
      check("rd350_direct", bus.q, 16'd350);

      // Every address: write then read the next cycle.
      for (int i = 0; i < int'(DEPTH); i++) begin
         di = WIDTH'($urandom);
         drive(1'b1, 1'b0, 1'b0, AW'(i), di, $sformatf("sweep_wr%0d", i));
         drive(1'b1, 1'b0, 1'b1, AW'(i), 16'h0000, $sformatf("sweep_rd%0d", i));
      end
      check("addr63_direct", bus.q, mdl[63]);

      // Deselected cycles ignore wen/a/d.
      drive(1'b1, 1'b0, 1'b0, 6'd5, 16'hAAAA, "ce_wr5");
      drive(1'b1, 1'b1, 1'b0, 6'd5, 16'h0F0F, "ce_idle0");
      drive(1'b1, 1'b1, 1'b1, 6'd6, 16'hF0F0, "ce_idle1");
      drive(1'b1, 1'b1, 1'b0, 6'd5, 16'h1357, "ce_idle2");
      drive(1'b1, 1'b0, 1'b1, 6'd5, 16'h0000, "ce_rd5");
      check("ce_rd5_direct", bus.q, 16'hAAAA);

      // No write-through: Q holds during a write.
      drive(1'b1, 1'b0, 1'b0, 6'd2, 16'h1234, "nwt_wr2");
      drive(1'b1, 1'b0, 1'b1, 6'd2, 16'h0000, "nwt_rd2");
      drive(1'b1, 1'b0, 1'b0, 6'd7, 16'hFFFF, "nwt_wr7_hold");
      check("nwt_hold_direct", bus.q, 16'h1234);
      drive(1'b1, 1'b0, 1'b1, 6'd7, 16'h0000, "nwt_rd7");

      // Last write wins.
      drive(1'b1, 1'b0, 1'b0, 6'd10, 16'h0001, "ww_a");
      drive(1'b1, 1'b0, 1'b0, 6'd10, 16'h8000, "ww_b");
      drive(1'b1, 1'b0, 1'b1, 6'd10, 16'h0000, "ww_rd");
      check("ww_direct", bus.q, 16'h8000);

      // Fill, then reset concurrently with a write to A=3.
      for (int i = 0; i < int'(DEPTH); i++) begin
         drive(1'b1, 1'b0, 1'b0, AW'(i), 16'hA000 | 16'(i), $sformatf("fill%0d", i));
      end
      drive(1'b1, 1'b0, 1'b1, 6'd3, 16'h0000, "fill_rd3");
      drive(1'b0, 1'b0, 1'b0, 6'd3, 16'h5555, "rst_vs_wr");
      check("rst_vs_wr_q", bus.q, 16'h0000);
      for (int i = 0; i < int'(DEPTH); i++) begin
         drive(1'b1, 1'b0, 1'b1, AW'(i), 16'h0000, $sformatf("post_rst_rd%0d", i));
      end

      drive(1'b1, 1'b1, 1'b1, 6'd0, 16'h0000, "idle_end");
      @(negedge clk);
      #1;
      check("sb_drain", WIDTH'(sb_val.size()), 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cmem.md
CMEM -- requirements
Module: cmem

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter DEPTH, default 64, number of addressable words.
REQ-003 Parameter AW, default 6, address width in bits; DEPTH SHALL equal 2**AW.
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 RSTN  input  1  reset; synchronous, active-low.
REQ-006 CEN  input  1  chip enable, active-low; 0 = access this cycle.
REQ-007 WEN  input  1  write enable, active-low; 0 = write, 1 = read (qualified by CEN=0).
REQ-008 A  input  AW  word address, 0..DEPTH-1.
REQ-009 D  input  WIDTH  write data.
REQ-010 Q  output  WIDTH  registered read data.

Function
REQ-011 The block SHALL be a single-port synchronous memory of DEPTH x WIDTH bits (64 x 16 at defaults).
REQ-012 Inputs CEN, WEN, A and D SHALL be sampled only at the CLK rising edge.
REQ-013 Write: CEN=0, WEN=0 at a rising edge SHALL store D into mem[A] at that edge.
REQ-014 Read: CEN=0, WEN=1 at a rising edge SHALL load mem[A] into Q at that edge; one-cycle latency, with Q valid immediately after the edge and stable until the next edge.
REQ-015 Q SHALL hold its previous value during a write cycle (no write-through).
REQ-016 CEN=1 SHALL perform no access: memory unchanged, Q held, and WEN, A and D ignored.
REQ-017 A read of an address written in the immediately preceding cycle SHALL return the newly written data.
REQ-018 Writing the same address repeatedly SHALL retain only the last written value.
REQ-019 All DEPTH addresses SHALL be independently addressable, with no aliasing; address DEPTH-1 (63) SHALL be fully usable.
REQ-020 Q SHALL be driven directly from a register, with no combinational path from any input to Q.
REQ-021 Unknown or X values on CEN or WEN in simulation SHALL NOT corrupt memory contents when RSTN=0.

Reset
REQ-022 With RSTN=0 at a rising edge, Q SHALL become 0 at that edge.
REQ-023 With RSTN=0 at a rising edge, all DEPTH memory words SHALL become 0 at that edge.
REQ-024 Reset SHALL take priority over any concurrent read or write requested in the same cycle.
REQ-025 When reset is asserted mid-operation, any access requested in that cycle SHALL be discarded.
REQ-026 On the first rising edge with RSTN=1, normal operation SHALL resume with no extra latency.
REQ-027 Before the first reset, memory and Q contents are undefined; the bench SHALL apply reset before checking any value.

Verification
REQ-028 Reset, then CEN=0, WEN=0, A=1, D=350; next cycle CEN=0, WEN=1, A=1 -> Q=350 after that edge.
REQ-029 For i=0..63, write D_i to A=i, then read A=i in the next cycle -> Q=D_i one cycle after each read; zero mismatches; covers addresses 0 and 63.
REQ-030 Write 0xAAAA to A=5, then hold CEN=1 for 3 cycles while toggling WEN, A and D -> Q unchanged, and a later read of A=5 returns 0xAAAA.
REQ-031 Read A=2 returning 0x1234, then write 0xFFFF to A=7 -> Q stays 0x1234 during the write cycle; a read of A=7 returns 0xFFFF.
REQ-032 Fill A=0..63 with nonzero data, then assert RSTN=0 for one cycle together with CEN=0, WEN=0, A=3, D=0x5555 -> Q=0, and every address subsequently reads 0, including A=3.
REQ-033 Write 0x0001 and then 0x8000 to A=10 on consecutive cycles -> a read of A=10 returns 0x8000.
